amux_scan_ctrl: RTL and testbench
=================================

// Module: amux_scan_ctrl
// PURPOSE
//  Sequences the analog mux tree (built from 2:1 AMUX cells) that feeds the on-chip ADC.
//  Scans the enabled channels round-robin. A software single-shot request pre-empts the scan.
//  Each conversion follows select -> settle -> convert -> capture. A break-before-make gap
//  separates every select change. Sits between the CPU register bank and the mux/ADC analog macros.
// PARAMETERS
//  NCH      4   number of mux channels (power of 2, >=2)
//  CHW      2   channel index width, log2(NCH)
//  SETTLE_W 8   width of settle-count input
//  DW       10  ADC result width
//  TMO      255 max cycles to wait for adc_done before abandoning the conversion
// PORTS
//  clk           in   1        system clock
//  reset         in   1        synchronous, active-high reset
//  enable        in   1        scan enable
//  ch_mask       in   NCH      per-channel scan enable, bit i = channel i
//  settle_cycles in   SETTLE_W settle delay after select, in clk cycles
//  sw_req        in   1        single-shot request; level, held until sw_ack
//  sw_ch         in   CHW      channel for the single shot; must be stable while sw_req=1
//  sw_ack        out  1        1-cycle pulse: single-shot result (or timeout) is presented
//  mux_sel       out  CHW      channel select to the mux tree
//  mux_en        out  1        mux output enable; 0 = all inputs open
//  adc_start     out  1        1-cycle conversion start pulse
//  adc_done      in   1        1-cycle pulse from the ADC: adc_data valid
//  adc_data      in   DW       ADC conversion result
//  res_valid     out  1        1-cycle pulse: res_ch/res_data valid
//  res_ch        out  CHW      channel of the presented result
//  res_data      out  DW       captured result, held until the next res_valid
//  tmo_err       out  1        1-cycle pulse: conversion abandoned after TMO cycles
//  busy          out  1        1 in any state other than IDLE
// BEHAVIOUR
//  Reset:
//   - All outputs are 0. State is IDLE.
//   - The round-robin pointer is set so the first scan channel is the lowest set bit of ch_mask.
//   - Reset during any state aborts immediately. adc_start is never issued after reset asserts.
//  States: IDLE, GAP, SELECT, SETTLE, CONVERT, CAPTURE.
//  IDLE:
//   - mux_en=0.
//   - Go to GAP when sw_req=1, or when enable=1 and ch_mask!=0. Otherwise stay.
//  GAP (1 cycle, mux_en=0):
//   - Chooses the channel and loads mux_sel.
//   - sw_req=1 has priority: the channel is sw_ch and a sw flag is set.
//   - Otherwise the channel is the next set ch_mask bit strictly after the last scanned channel,
//     wrapping NCH-1 -> 0. If only one bit is set, that channel is rescanned.
//   - mux_sel changes only in GAP. It is stable whenever mux_en=1.
//  SELECT (1 cycle):
//   - mux_en=1. Loads the settle counter with max(settle_cycles,1).
//  SETTLE:
//   - mux_en=1. Decrement the counter; when it reaches 1, go to CONVERT.
//   - settle_cycles=0 is treated as 1.
//  CONVERT:
//   - adc_start=1 on the first cycle only.
//   - Waits for adc_done and counts cycles.
//   - adc_done in the same cycle as adc_start is valid.
//   - No adc_done after TMO cycles: pulse tmo_err, do not pulse res_valid,
//     and pulse sw_ack if the sw flag is set. Then go to GAP or IDLE (rules below).
//  CAPTURE (1 cycle):
//   - Register adc_data -> res_data and the channel -> res_ch. Pulse res_valid.
//   - Pulse sw_ack if the sw flag is set. Clear the sw flag.
//   - Round-robin pointer advances only for scan conversions, never for sw shots.
//  After CAPTURE or a timeout:
//   - Go to GAP when sw_req is pending, or when enable=1 and ch_mask!=0. Else go to IDLE.
//  Timing: mux_en=0 for at least 1 cycle between consecutive conversions.
//  Latency, settle_cycles=3, adc_done k cycles after adc_start:
//   - Cycle 0 GAP, cycle 1 SELECT, cycles 2-4 SETTLE, adc_start at cycle 5.
//   - res_valid at cycle 5+k+1.
//  Mid-operation changes:
//   - enable falling or ch_mask changing mid-conversion does not abort.
//     The current conversion completes and is reported.
//   - Masking the channel under conversion still reports its result.
//  adc_done outside CONVERT is ignored.
//  sw_req with sw_ch >= NCH is not possible: CHW = log2(NCH).
// TESTING
//  1. reset; enable=1, ch_mask=4'b1011, settle=2, ADC done 3 cycles after start
//     -> res_ch sequence 0,1,3,0,1; res_valid spacing constant; mux_en low 1 cycle between.
//  2. Scanning channel 1; raise sw_req, sw_ch=2
//     -> channel 1 result reported, next conversion is channel 2 with sw_ack;
//        scan then resumes at channel 3.
//  3. settle_cycles=0 and settle_cycles=255 -> adc_start 1 and 255 cycles after SELECT exit.
//  4. adc_done never asserted -> tmo_err after TMO cycles, no res_valid, next channel proceeds.
//     With the sw flag set: sw_ack also pulses.
//  5. Drop enable during CONVERT -> result still reported, then IDLE with busy=0, mux_en=0.
//  6. Assert reset in SETTLE and in CONVERT -> next cycle all outputs 0, state IDLE,
//     no adc_start; stray adc_done ignored.

Source files
------------

// File: rtl/amux_scan_ctrl.sv
// Analog mux scan sequencer: round-robin channel scan with single-shot pre-emption,
// break-before-make select changes and a bounded wait for the ADC.
module amux_scan_ctrl #(
  parameter int NCH      = 4,
  parameter int CHW      = 2,
  parameter int SETTLE_W = 8,
  parameter int DW       = 10,
  parameter int TMO      = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [NCH-1:0]      ch_mask,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic                sw_req,
  input  logic [CHW-1:0]      sw_ch,
  output logic                sw_ack,
  output logic [CHW-1:0]      mux_sel,
  output logic                mux_en,
  output logic                adc_start,
  input  logic                adc_done,
  input  logic [DW-1:0]       adc_data,
  output logic                res_valid,
  output logic [CHW-1:0]      res_ch,
  output logic [DW-1:0]       res_data,
  output logic                tmo_err,
  output logic                busy
);

  localparam int TW = $clog2(TMO + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GAP     = 3'd1;
  localparam logic [2:0] S_SELECT  = 3'd2;
  localparam logic [2:0] S_SETTLE  = 3'd3;
  localparam logic [2:0] S_CONVERT = 3'd4;
  localparam logic [2:0] S_CAPTURE = 3'd5;

  logic [2:0]          r_state;
  logic [CHW-1:0]      r_sel;
  logic [CHW-1:0]      r_last;
  logic                r_sw;
  logic [SETTLE_W-1:0] r_settle;
  logic [TW-1:0]       r_tcnt;
  logic [CHW-1:0]      r_res_ch;
  logic [DW-1:0]       r_res_data;

  logic [CHW-1:0]      w_next_ch;
  logic                w_found;
  logic                w_tmo;
  logic                w_done;
  logic                w_go;

  // Next set mask bit strictly after r_last; NCH is a power of two so the index wraps naturally.
  always_comb begin : rr_pick
    logic [CHW-1:0] v_idx;
    w_next_ch = r_last;
    w_found   = 1'b0;
    v_idx     = '0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      v_idx = r_last + CHW'(i);
      if (!w_found && ch_mask[v_idx]) begin
        w_next_ch = v_idx;
        w_found   = 1'b1;
      end
    end
  end

  // The request currently being acknowledged (r_sw) is not counted as pending again.
  assign w_go   = (sw_req && !r_sw) || (enable && (ch_mask != '0));
  assign w_tmo  = (r_state == S_CONVERT) && (r_tcnt == TW'(TMO));
  assign w_done = (r_state == S_CONVERT) && adc_done && !w_tmo;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_sel      <= '0;
      r_last     <= '1;
      r_sw       <= 1'b0;
      r_settle   <= '0;
      r_tcnt     <= '0;
      r_res_ch   <= '0;
      r_res_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_go) r_state <= S_GAP;
        end
        S_GAP: begin
          if (sw_req) begin
            r_sel   <= sw_ch;
            r_sw    <= 1'b1;
            r_state <= S_SELECT;
          end else if (enable && w_found) begin
            r_sel   <= w_next_ch;
            r_sw    <= 1'b0;
            r_state <= S_SELECT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SELECT: begin
          r_settle <= (settle_cycles == '0) ? SETTLE_W'(1) : settle_cycles;
          r_state  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_settle <= SETTLE_W'(1)) begin
            r_tcnt  <= '0;
            r_state <= S_CONVERT;
          end else begin
            r_settle <= r_settle - SETTLE_W'(1);
          end
        end
        S_CONVERT: begin
          if (w_done) begin
            r_res_data <= adc_data;
            r_res_ch   <= r_sel;
            r_state    <= S_CAPTURE;
          end else if (w_tmo) begin
            // A dead scan channel still advances the pointer so the scan cannot stall on it.
            if (!r_sw) r_last <= r_sel;
            r_sw    <= 1'b0;
            r_state <= w_go ? S_GAP : S_IDLE;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        S_CAPTURE: begin
          if (!r_sw) r_last <= r_sel;
          r_sw    <= 1'b0;
          r_state <= w_go ? S_GAP : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mux_sel   = r_sel;
  assign mux_en    = (r_state == S_SELECT) || (r_state == S_SETTLE) ||
                     (r_state == S_CONVERT) || (r_state == S_CAPTURE);
  assign adc_start = (r_state == S_CONVERT) && (r_tcnt == '0);
  assign res_valid = (r_state == S_CAPTURE);
  assign res_ch    = r_res_ch;
  assign res_data  = r_res_data;
  assign tmo_err   = w_tmo;
  assign sw_ack    = r_sw && ((r_state == S_CAPTURE) || w_tmo);
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_amux_scan_ctrl.sv
// Bench for amux_scan_ctrl: per-conversion timeline model checked every cycle,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_amux_scan_ctrl;

  localparam int NCH      = 4;
  localparam int CHW      = 2;
  localparam int SETTLE_W = 8;
  localparam int DW       = 10;
  localparam int TMO      = 255;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                enable = 1'b0;
  logic [NCH-1:0]      ch_mask = '0;
  logic [SETTLE_W-1:0] settle_cycles = '0;
  logic                sw_req = 1'b0;
  logic [CHW-1:0]      sw_ch = '0;
  logic                sw_ack;
  logic [CHW-1:0]      mux_sel;
  logic                mux_en;
  logic                adc_start;
  logic                adc_done = 1'b0;
  logic [DW-1:0]       adc_data = '0;
  logic                res_valid;
  logic [CHW-1:0]      res_ch;
  logic [DW-1:0]       res_data;
  logic                tmo_err;
  logic                busy;

  amux_scan_ctrl #(.NCH(NCH), .CHW(CHW), .SETTLE_W(SETTLE_W), .DW(DW), .TMO(TMO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .ch_mask(ch_mask),
    .settle_cycles(settle_cycles), .sw_req(sw_req), .sw_ch(sw_ch), .sw_ack(sw_ack),
    .mux_sel(mux_sel), .mux_en(mux_en), .adc_start(adc_start), .adc_done(adc_done),
    .adc_data(adc_data), .res_valid(res_valid), .res_ch(res_ch), .res_data(res_data),
    .tmo_err(tmo_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 0;

  // Model: a conversion is a timeline indexed by m_t (0 = gap, 1 = select,
  // 2..1+N = settle, 2+N+k = k-th convert cycle), plus a capture flag.
  bit          m_idle = 1, m_cap = 0, m_sw = 0;
  int          m_t = -1, m_n = 1, m_ch = 0, m_sel = 0, m_last = NCH - 1, m_res_ch = 0;
  logic [DW-1:0] m_res_data = '0;

  // Stimulus / ADC responder controls
  bit rand_mode = 0, never = 0, force_done = 0, ack_prev = 0, prev_en = 0;
  int fixed_delay = 3, resp_cnt = -1, fall_cyc = 0;

  int q_res_ch[$], q_res_cyc[$], q_start_cyc[$], q_start_ch[$], q_tmo_cyc[$];
  int q_ack_cyc[$], q_rise_cyc[$], q_low[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic int next_after(input int last, input logic [NCH-1:0] m);
    for (int d = 1; d <= NCH; d++)
      if (m[(last + d) % NCH]) return (last + d) % NCH;
    return last;
  endfunction

  task automatic model_step();
    bit go;
    int k;
    go = (sw_req && !m_sw) || (enable && (ch_mask != '0));
    if (reset) begin
      m_idle = 1; m_cap = 0; m_sw = 0; m_t = -1; m_sel = 0;
      m_last = NCH - 1; m_res_ch = 0; m_res_data = '0;
    end else if (m_idle) begin
      if (sw_req || (enable && (ch_mask != '0))) begin m_idle = 0; m_t = 0; end
    end else if (m_cap) begin
      if (!m_sw) m_last = m_ch;
      m_sw = 0; m_cap = 0;
      if (go) m_t = 0; else m_idle = 1;
    end else if (m_t == 0) begin
      if (sw_req) begin
        m_ch = int'(sw_ch); m_sw = 1; m_t = 1; m_sel = m_ch;
      end else if (enable && (ch_mask != '0)) begin
        m_ch = next_after(m_last, ch_mask); m_sw = 0; m_t = 1; m_sel = m_ch;
      end else m_idle = 1;
    end else if (m_t == 1) begin
      m_n = (settle_cycles == '0) ? 1 : int'(settle_cycles);
      m_t = 2;
    end else if (m_t < 2 + m_n) begin
      m_t++;
    end else begin
      k = m_t - 2 - m_n;
      if (adc_done && k < TMO) begin
        m_res_data = adc_data; m_res_ch = m_ch; m_cap = 1;
      end else if (k == TMO) begin
        if (!m_sw) m_last = m_ch;
        m_sw = 0;
        if (go) m_t = 0; else m_idle = 1;
      end else m_t++;
    end
  endtask

  task automatic compare();
    bit conv, e_tmo;
    int k;
    conv  = !m_idle && !m_cap && (m_t >= 2 + m_n);
    k     = m_t - 2 - m_n;
    e_tmo = conv && (k == TMO);
    check("busy",      32'(busy),      32'(!m_idle));
    check("mux_en",    32'(mux_en),    32'(!m_idle && (m_cap || m_t >= 1)));
    check("mux_sel",   32'(mux_sel),   32'(m_sel));
    check("adc_start", 32'(adc_start), 32'(conv && k == 0));
    check("tmo_err",   32'(tmo_err),   32'(e_tmo));
    check("res_valid", 32'(res_valid), 32'(m_cap));
    check("sw_ack",    32'(sw_ack),    32'(m_sw && (m_cap || e_tmo)));
    check("res_ch",    32'(res_ch),    32'(m_res_ch));
    check("res_data",  32'(res_data),  32'(m_res_data));
  endtask

  task automatic tick();
    bit dropped;
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    if (chk_en) compare();
    if (res_valid) begin q_res_ch.push_back(int'(res_ch)); q_res_cyc.push_back(cyc); end
    if (adc_start) begin q_start_cyc.push_back(cyc); q_start_ch.push_back(int'(mux_sel)); end
    if (tmo_err) q_tmo_cyc.push_back(cyc);
    if (sw_ack) q_ack_cyc.push_back(cyc);
    if (mux_en && !prev_en) begin q_rise_cyc.push_back(cyc); q_low.push_back(cyc - fall_cyc); end
    if (!mux_en && prev_en) fall_cyc = cyc;
    prev_en = mux_en;
    // requester drops sw_req one cycle after seeing the acknowledge
    dropped = ack_prev;
    if (ack_prev) sw_req = 1'b0;
    ack_prev = sw_ack;
    if (rand_mode) begin
      if ($urandom_range(49) == 0) enable = ~enable;
      if ($urandom_range(79) == 0) ch_mask = NCH'($urandom);
      if ($urandom_range(99) == 0) settle_cycles = SETTLE_W'($urandom_range(6));
      if (!sw_req && !dropped && $urandom_range(59) == 0) begin
        sw_req = 1'b1; sw_ch = CHW'($urandom);
      end
      reset = ($urandom_range(499) == 0);
    end
    adc_done = 1'b0;
    adc_data = DW'($urandom);
    if (adc_start) begin
      if (never || (rand_mode && $urandom_range(39) == 0)) resp_cnt = -1;
      else resp_cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(10));
    end
    if (resp_cnt == 0) begin adc_done = 1'b1; resp_cnt = -1; end
    else if (resp_cnt > 0) resp_cnt--;
    else if (force_done || (rand_mode && $urandom_range(14) == 0)) adc_done = 1'b1;
  endtask

  function automatic int qcount(input int which);
    case (which)
      0:       return q_res_cyc.size();
      1:       return q_start_cyc.size();
      2:       return q_tmo_cyc.size();
      default: return q_rise_cyc.size();
    endcase
  endfunction

  task automatic run_until(input int which, input int n, input int budget, input string nm);
    int c = 0;
    while (qcount(which) < n && c < budget) begin tick(); c++; end
    check({nm, "_reached"}, 32'(qcount(which) >= n), 32'(1));
  endtask

  task automatic clear_q();
    q_res_ch.delete(); q_res_cyc.delete(); q_start_cyc.delete(); q_start_ch.delete();
    q_tmo_cyc.delete(); q_ack_cyc.delete(); q_rise_cyc.delete(); q_low.delete();
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_busy"}, 32'(busy), 0);       check({nm, "_mux_en"}, 32'(mux_en), 0);
    check({nm, "_mux_sel"}, 32'(mux_sel), 0); check({nm, "_start"}, 32'(adc_start), 0);
    check({nm, "_tmo"}, 32'(tmo_err), 0);     check({nm, "_valid"}, 32'(res_valid), 0);
    check({nm, "_ack"}, 32'(sw_ack), 0);      check({nm, "_res_ch"}, 32'(res_ch), 0);
    check({nm, "_res_data"}, 32'(res_data), 0);
  endtask

  task automatic do_reset(input string nm);
    enable = 1'b0; sw_req = 1'b0; force_done = 0; never = 0; resp_cnt = -1;
    reset = 1'b1;
    tick();
    check_all_zero(nm);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_a[5] = '{0, 1, 3, 0, 1};
    tick();
    chk_en = 1;

    // Basic scan over mask 1011
    do_reset("rst_a");
    enable = 1'b1; ch_mask = 4'b1011; settle_cycles = 2; fixed_delay = 3;
    clear_q();
    run_until(0, 5, 100, "scan5");
    for (int i = 0; i < 5; i++) check("scan_seq", 32'(at(q_res_ch, i)), 32'(exp_a[i]));
    for (int i = 0; i < 4; i++)
      check("scan_spacing", 32'(at(q_res_cyc, i + 1) - at(q_res_cyc, i)), 32'(9));
    for (int i = 1; i < 5; i++) check("bbm_gap", 32'(at(q_low, i)), 32'(1));

    // Single-shot pre-empts the scan after channel 1
    do_reset("rst_b");
    enable = 1'b1; ch_mask = 4'b1011; settle_cycles = 2; fixed_delay = 3;
    clear_q();
    run_until(0, 1, 50, "b_first");
    for (int c = 0; c < 50 && !(mux_en && mux_sel == 2'd1); c++) tick();
    sw_req = 1'b1; sw_ch = 2'd2;
    clear_q();
    run_until(0, 3, 100, "b_res3");
    check("sw_seq0", 32'(at(q_res_ch, 0)), 32'(1));
    check("sw_seq1", 32'(at(q_res_ch, 1)), 32'(2));
    check("sw_seq2", 32'(at(q_res_ch, 2)), 32'(3));
    check("sw_ack_count", 32'(q_ack_cyc.size()), 32'(1));
    check("sw_ack_with_res", 32'(at(q_ack_cyc, 0)), 32'(at(q_res_cyc, 1)));

    // Settle extremes
    for (int s = 0; s < 2; s++) begin
      do_reset("rst_c");
      enable = 1'b1; ch_mask = 4'b0001; fixed_delay = 0;
      settle_cycles = (s == 0) ? 8'd0 : 8'd255;
      clear_q();
      run_until(1, 1, 400, "c_start");
      check("settle_delay", 32'(at(q_start_cyc, 0) - at(q_rise_cyc, 0) - 1),
            32'((s == 0) ? 1 : 255));
    end

    // Timeouts, scan then single-shot
    do_reset("rst_d");
    enable = 1'b1; ch_mask = 4'b0011; settle_cycles = 1; never = 1;
    clear_q();
    run_until(2, 1, 400, "d_tmo1");
    check("tmo_delay", 32'(at(q_tmo_cyc, 0) - at(q_start_cyc, 0)), 32'(TMO));
    check("tmo_no_res", 32'(q_res_cyc.size()), 32'(0));
    check("tmo_no_ack", 32'(q_ack_cyc.size()), 32'(0));
    run_until(1, 2, 400, "d_start2");
    check("tmo_next_ch", 32'(at(q_start_ch, 1)), 32'(1));
    sw_req = 1'b1; sw_ch = 2'd3;
    clear_q();
    run_until(2, 2, 800, "d_tmo2");
    check("tmo_sw_ch", 32'(at(q_start_ch, 0)), 32'(3));
    check("tmo_sw_ack_count", 32'(q_ack_cyc.size()), 32'(1));
    check("tmo_sw_ack_when", 32'(at(q_ack_cyc, 0)), 32'(at(q_tmo_cyc, 1)));
    check("tmo_sw_no_res", 32'(q_res_cyc.size()), 32'(0));

    // Enable drops during CONVERT
    do_reset("rst_e");
    enable = 1'b1; ch_mask = 4'b0100; settle_cycles = 1; fixed_delay = 5;
    clear_q();
    run_until(1, 1, 50, "e_start");
    enable = 1'b0;
    run_until(0, 1, 50, "e_res");
    check("e_res_ch", 32'(at(q_res_ch, 0)), 32'(2));
    tick(); tick();
    check("e_idle_busy", 32'(busy), 32'(0));
    check("e_idle_mux_en", 32'(mux_en), 32'(0));
    check("e_res_held", 32'(res_ch), 32'(2));

    // Reset in SETTLE and in CONVERT, with stray adc_done
    do_reset("rst_f");
    enable = 1'b1; ch_mask = 4'b1111; settle_cycles = 5; fixed_delay = 3;
    clear_q();
    run_until(3, 1, 50, "f_select");
    tick();
    reset = 1'b1; force_done = 1;
    tick();
    check_all_zero("rst_settle");
    reset = 1'b0; enable = 1'b0;
    clear_q();
    repeat (5) tick();
    check("f_stray_no_start", 32'(q_start_cyc.size()), 32'(0));
    check("f_stray_idle", 32'(busy), 32'(0));
    force_done = 0; enable = 1'b1;
    run_until(1, 1, 50, "f_start");
    reset = 1'b1;
    clear_q();
    tick();
    check_all_zero("rst_convert");
    repeat (3) tick();
    reset = 1'b0; enable = 1'b0;
    repeat (4) tick();
    check("f_no_start_after_rst", 32'(q_start_cyc.size()), 32'(0));
    check("f_no_res_after_rst", 32'(q_res_cyc.size()), 32'(0));

    // Randomized traffic against the model
    do_reset("rst_g");
    enable = 1'b1; ch_mask = 4'b1111; settle_cycles = 2; fixed_delay = -1;
    rand_mode = 1;
    repeat (3000) tick();
    rand_mode = 0; reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
